// File: rtl/stack_unit.sv
// Downward-growing 32-bit hardware stack with 1-cycle registered pop path.
// Optional macro STACK_PEEK_EN adds a registered top-of-stack output.
module stack_unit #(
  parameter int          DEPTH   = 16,
  parameter logic [31:0] SP_BASE = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PushM,
  input  logic        PopM,
  input  logic [31:0] PushDataM,
  input  logic        ClearErrM,
  output logic [31:0] PopDataW,
  output logic        PopValidW,
  output logic [31:0] StackPointer,
  output logic        StackFull,
  output logic        StackEmpty,
  output logic        StackOverflow,
`ifdef STACK_PEEK_EN
  output logic        StackUnderflow,
  output logic [31:0] TopOfStackM
`else
  output logic        StackUnderflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [31:0]   r_sp;
  logic [31:0]   r_pop_data;
  logic          r_pop_valid;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;
  logic          r_unf;

  logic          w_empty;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;
  logic          w_swap;
  logic          w_bypass;
  logic          w_ovf;
  logic          w_unf;
  logic [AW-1:0] w_top_idx;
  logic [AW-1:0] w_wr_idx;
  logic [31:0]   w_top;
  logic [CW-1:0] w_cnt_nxt;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_push = PushM & ~PopM & ~w_full;
  assign w_do_pop  = PopM & ~PushM & ~w_empty;
  assign w_swap    = PushM & PopM & ~w_empty;
  assign w_bypass  = PushM & PopM & w_empty;
  assign w_ovf     = PushM & ~PopM & w_full;
  assign w_unf     = PopM & ~PushM & w_empty;
  assign w_top_idx = AW'(r_count - CW'(1));
  assign w_wr_idx  = AW'(r_count);
  assign w_top     = r_mem[w_top_idx];

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_do_push)
      w_cnt_nxt = r_count + CW'(1);
    else if (w_do_pop)
      w_cnt_nxt = r_count - CW'(1);
  end

  // Storage is intentionally not reset; entries above count are dead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_do_push)
        r_mem[w_wr_idx] <= PushDataM;
      else if (w_swap)
        r_mem[w_top_idx] <= PushDataM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_sp        <= SP_BASE;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      r_count     <= w_cnt_nxt;
      r_full      <= (w_cnt_nxt == CW'(DEPTH));
      r_empty     <= (w_cnt_nxt == '0);
      r_pop_valid <= w_do_pop | w_swap | w_bypass;
      if (w_do_pop | w_swap)
        r_pop_data <= w_top;
      else if (w_bypass)
        r_pop_data <= PushDataM;
      if (w_do_push)
        r_sp <= r_sp - 32'd4;
      else if (w_do_pop)
        r_sp <= r_sp + 32'd4;
      // A new error in the clearing cycle wins over the clear.
      r_ovf <= (r_ovf & ~ClearErrM) | w_ovf;
      r_unf <= (r_unf & ~ClearErrM) | w_unf;
    end
  end

`ifdef STACK_PEEK_EN
  logic [31:0]   r_peek;
  logic [31:0]   w_peek_nxt;
  logic [AW-1:0] w_sec_idx;

  assign w_sec_idx = AW'(r_count - CW'(2));

  always_comb begin
    w_peek_nxt = r_peek;
    if (w_do_push | w_swap)
      w_peek_nxt = PushDataM;
    else if (w_do_pop)
      w_peek_nxt = (r_count == CW'(1)) ? 32'd0 : r_mem[w_sec_idx];
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_peek <= '0;
    else
      r_peek <= w_peek_nxt;
  end

  assign TopOfStackM = r_peek;
`endif

  assign PopDataW       = r_pop_data;
  assign PopValidW      = r_pop_valid;
  assign StackPointer   = r_sp;
  assign StackFull      = r_full;
  assign StackEmpty     = r_empty;
  assign StackOverflow  = r_ovf;
  assign StackUnderflow = r_unf;

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit (default DEPTH/SP_BASE).
// Covers push/pop, full/overflow, underflow, bypass/swap and reset.
module tb_stack_unit;

  logic        clk;
  logic        rst;
  logic        PushM;
  logic        PopM;
  logic [31:0] PushDataM;
  logic        ClearErrM;
  logic [31:0] PopDataW;
  logic        PopValidW;
  logic [31:0] StackPointer;
  logic        StackFull;
  logic        StackEmpty;
  logic        StackOverflow;
  logic        StackUnderflow;
`ifdef STACK_PEEK_EN
  logic [31:0] TopOfStackM;
`endif

  int checks;
  int failures;

  stack_unit dut (
    .clk           (clk),
    .rst           (rst),
    .PushM         (PushM),
    .PopM          (PopM),
    .PushDataM     (PushDataM),
    .ClearErrM     (ClearErrM),
    .PopDataW      (PopDataW),
    .PopValidW     (PopValidW),
    .StackPointer  (StackPointer),
    .StackFull     (StackFull),
    .StackEmpty    (StackEmpty),
    .StackOverflow (StackOverflow),
`ifdef STACK_PEEK_EN
    .StackUnderflow(StackUnderflow),
    .TopOfStackM   (TopOfStackM)
`else
    .StackUnderflow(StackUnderflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic pu, input logic po,
                      input logic [31:0] d, input logic ce);
    rst       = r;
    PushM     = pu;
    PopM      = po;
    PushDataM = d;
    ClearErrM = ce;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    PushM     = 1'b0;
    PopM      = 1'b0;
    ClearErrM = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    checks++;
    if (StackPointer !== 32'h400) begin
      failures++;
      $display("FAIL reset_sp got=%h exp=%h", StackPointer, 32'h400);
    end
    checks++;
    if ({StackEmpty, StackFull, PopValidW} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=100",
               {StackEmpty, StackFull, PopValidW});
    end
    checks++;
    if ({PopDataW, StackOverflow, StackUnderflow} !== 34'd0) begin
      failures++;
      $display("FAIL reset_data_err got=%h/%b%b exp=0", PopDataW,
               StackOverflow, StackUnderflow);
    end
  endtask

  task automatic test_push_pop();
    step(0, 1, 0, 32'h11, 0);
    step(0, 1, 0, 32'h22, 0);
    step(0, 1, 0, 32'h33, 0);
    checks++;
    if (StackPointer !== 32'h3F4 || StackEmpty !== 1'b0) begin
      failures++;
      $display("FAIL push3_sp got=%h/%b exp=3f4/0", StackPointer, StackEmpty);
    end
    step(0, 0, 1, 0, 0);
    checks++;
    if (PopDataW !== 32'h33 || PopValidW !== 1'b1) begin
      failures++;
      $display("FAIL pop_33 got=%h/%b exp=33/1", PopDataW, PopValidW);
    end
    checks++;
    if (StackPointer !== 32'h3F8) begin
      failures++;
      $display("FAIL pop_sp got=%h exp=3f8", StackPointer);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (PopValidW !== 1'b0 || PopDataW !== 32'h33) begin
      failures++;
      $display("FAIL idle_valid got=%b/%h exp=0/33", PopValidW, PopDataW);
    end
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    checks++;
    if (PopDataW !== 32'h11 || StackEmpty !== 1'b1 ||
        StackPointer !== 32'h400) begin
      failures++;
      $display("FAIL pop_last got=%h/%b/%h exp=11/1/400",
               PopDataW, StackEmpty, StackPointer);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++)
      step(0, 1, 0, 32'(i), 0);
    checks++;
    if (StackFull !== 1'b1 || StackOverflow !== 1'b0 ||
        StackPointer !== 32'h3C0) begin
      failures++;
      $display("FAIL fill16 got=%b/%b/%h exp=1/0/3c0",
               StackFull, StackOverflow, StackPointer);
    end
    step(0, 1, 0, 32'hAA, 0);
    checks++;
    if (StackFull !== 1'b1 || StackOverflow !== 1'b1 ||
        StackPointer !== 32'h3C0) begin
      failures++;
      $display("FAIL ovf got=%b/%b/%h exp=1/1/3c0",
               StackFull, StackOverflow, StackPointer);
    end
    step(0, 0, 1, 0, 0);
    checks++;
    if (PopDataW !== 32'd15 || PopValidW !== 1'b1 || StackFull !== 1'b0) begin
      failures++;
      $display("FAIL pop_after_ovf got=%h/%b/%b exp=f/1/0",
               PopDataW, PopValidW, StackFull);
    end
    step(0, 1, 0, 32'h77, 0);
    step(0, 1, 1, 32'h88, 0);
    checks++;
    if (PopDataW !== 32'h77 || PopValidW !== 1'b1 || StackFull !== 1'b1 ||
        StackPointer !== 32'h3C0) begin
      failures++;
      $display("FAIL swap_full got=%h/%b/%b/%h exp=77/1/1/3c0",
               PopDataW, PopValidW, StackFull, StackPointer);
    end
    step(0, 0, 1, 0, 0);
    checks++;
    if (PopDataW !== 32'h88) begin
      failures++;
      $display("FAIL pop_swapped got=%h exp=88", PopDataW);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (StackOverflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=0", StackOverflow);
    end
    step(1, 0, 0, 0, 0);
  endtask

  task automatic test_underflow();
    step(0, 1, 0, 32'h44, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    checks++;
    if (StackUnderflow !== 1'b1 || PopValidW !== 1'b0 ||
        PopDataW !== 32'h44 || StackPointer !== 32'h400) begin
      failures++;
      $display("FAIL unf got=%b/%b/%h/%h exp=1/0/44/400",
               StackUnderflow, PopValidW, PopDataW, StackPointer);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (StackUnderflow !== 1'b0) begin
      failures++;
      $display("FAIL unf_clear got=%b exp=0", StackUnderflow);
    end
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    checks++;
    if (StackUnderflow !== 1'b1) begin
      failures++;
      $display("FAIL unf_clear_race got=%b exp=1", StackUnderflow);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_bypass();
    step(0, 1, 1, 32'h5A, 0);
    checks++;
    if (PopDataW !== 32'h5A || PopValidW !== 1'b1 || StackEmpty !== 1'b1 ||
        StackUnderflow !== 1'b0 || StackPointer !== 32'h400) begin
      failures++;
      $display("FAIL bypass got=%h/%b/%b/%b/%h exp=5a/1/1/0/400",
               PopDataW, PopValidW, StackEmpty, StackUnderflow, StackPointer);
    end
    step(0, 1, 0, 32'h7, 0);
    step(0, 1, 1, 32'h9, 0);
    checks++;
    if (PopDataW !== 32'h7 || PopValidW !== 1'b1 ||
        StackPointer !== 32'h3FC) begin
      failures++;
      $display("FAIL swap1 got=%h/%b/%h exp=7/1/3fc",
               PopDataW, PopValidW, StackPointer);
    end
    step(0, 0, 1, 0, 0);
    checks++;
    if (PopDataW !== 32'h9 || StackEmpty !== 1'b1) begin
      failures++;
      $display("FAIL pop_after_swap got=%h/%b exp=9/1", PopDataW, StackEmpty);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 32'h1, 0);
    step(1, 0, 1, 0, 0);
    checks++;
    if (PopValidW !== 1'b0 || StackPointer !== 32'h400 ||
        PopDataW !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid got=%b/%h/%h exp=0/400/0",
               PopValidW, StackPointer, PopDataW);
    end
    checks++;
    if ({StackEmpty, StackFull, StackOverflow, StackUnderflow} !== 4'b1000) begin
      failures++;
      $display("FAIL rst_mid_flags got=%b exp=1000",
               {StackEmpty, StackFull, StackOverflow, StackUnderflow});
    end
  endtask

`ifdef STACK_PEEK_EN
  task automatic test_peek();
    step(0, 1, 0, 32'hC0DE, 0);
    checks++;
    if (TopOfStackM !== 32'hC0DE) begin
      failures++;
      $display("FAIL peek_push got=%h exp=c0de", TopOfStackM);
    end
    step(0, 0, 1, 0, 0);
    checks++;
    if (TopOfStackM !== 32'h0) begin
      failures++;
      $display("FAIL peek_pop got=%h exp=0", TopOfStackM);
    end
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    PushM     = 1'b0;
    PopM      = 1'b0;
    PushDataM = '0;
    ClearErrM = 1'b0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_bypass();
    test_reset_mid();
`ifdef STACK_PEEK_EN
    test_peek();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
